// File: rtl/rggen_register_host.sv
// rtl/rggen_register_host.sv - register access bus initiator: host command in, per-register replies merged into one response
module rggen_register_host #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int REGISTERS      = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0]        i_cmd_address,
    input  logic                            i_cmd_write,
    input  logic [DATA_WIDTH-1:0]           i_cmd_write_data,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [DATA_WIDTH-1:0]           o_rsp_read_data,
    output logic [1:0]                      o_rsp_status,
    output logic                            o_register_request,
    output logic [ADDRESS_WIDTH-1:0]        o_register_address,
    output logic                            o_register_write,
    output logic [DATA_WIDTH-1:0]           o_register_write_data,
    input  logic [REGISTERS-1:0]            i_register_select,
    input  logic [REGISTERS-1:0]            i_register_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_register_read_data,
    input  logic [REGISTERS*2-1:0]          i_register_status
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCESS   = 2'd1;
    localparam logic [1:0] RESPONSE = 2'd2;

    localparam logic [1:0] STATUS_OKAY         = 2'b00;
    localparam logic [1:0] STATUS_EXOKAY       = 2'b01;
    localparam logic [1:0] STATUS_SLAVE_ERROR  = 2'b10;
    localparam logic [1:0] STATUS_DECODE_ERROR = 2'b11;

    // Counter is one bit wider than strictly needed so it can never wrap.
    localparam int              CW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE      = CW'(1);
    localparam logic [REGISTERS-1:0] SEL_ONE = REGISTERS'(1);

    logic [1:0]               r_state;
    logic [CW-1:0]            r_counter;
    logic                     r_request;
    logic [ADDRESS_WIDTH-1:0] r_address;
    logic                     r_write;
    logic [DATA_WIDTH-1:0]    r_write_data;
    logic                     r_rsp_valid;
    logic [DATA_WIDTH-1:0]    r_rsp_read_data;
    logic [1:0]               r_rsp_status;

    logic                     w_single_select;
    logic                     w_sel_ready;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [1:0]               w_sel_status;
    logic [1:0]               w_mapped_status;

    // Exactly one select bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_single_select = (i_register_select != '0) &&
                             ((i_register_select & (i_register_select - SEL_ONE)) == '0);

    // Merge the selected slot's reply; only meaningful when exactly one slot is selected.
    always_comb begin
        w_sel_ready  = 1'b0;
        w_sel_data   = '0;
        w_sel_status = '0;
        for (int k = 0; k < REGISTERS; k++) begin
            if (i_register_select[k]) begin
                w_sel_ready  = w_sel_ready | i_register_ready[k];
                w_sel_data   = w_sel_data | i_register_read_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_status = w_sel_status | i_register_status[2*k +: 2];
            end
        end
    end

    // EXOKAY has no meaning to the host side and is folded into OKAY.
    assign w_mapped_status = (w_sel_status == STATUS_EXOKAY) ? STATUS_OKAY : w_sel_status;

    // Command acceptance, access sequencing with timeout, and response holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_counter       <= '0;
            r_request       <= 1'b0;
            r_address       <= '0;
            r_write         <= 1'b0;
            r_write_data    <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_read_data <= '0;
            r_rsp_status    <= STATUS_OKAY;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_address    <= i_cmd_address;
                        r_write      <= i_cmd_write;
                        r_write_data <= i_cmd_write_data;
                        r_counter    <= '0;
                        r_request    <= 1'b1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!w_single_select) begin
                        r_rsp_read_data <= '0;
                        r_rsp_status    <= STATUS_DECODE_ERROR;
                        r_request       <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RESPONSE;
                    end else if (w_sel_ready) begin
                        r_rsp_read_data <= r_write ? '0 : w_sel_data;
                        r_rsp_status    <= w_mapped_status;
                        r_request       <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RESPONSE;
                    end else if (r_counter == TIMEOUT_LAST) begin
                        r_rsp_read_data <= '0;
                        r_rsp_status    <= STATUS_SLAVE_ERROR;
                        r_request       <= 1'b0;
                        r_rsp_valid     <= 1'b1;
                        r_state         <= RESPONSE;
                    end else begin
                        r_counter <= r_counter + CNT_ONE;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_request   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_cmd_ready           = (r_state == IDLE) && !rst;
    assign o_rsp_valid           = r_rsp_valid;
    assign o_rsp_read_data       = r_rsp_read_data;
    assign o_rsp_status          = r_rsp_status;
    assign o_register_request    = r_request;
    assign o_register_address    = r_address;
    assign o_register_write      = r_write;
    assign o_register_write_data = r_write_data;

endmodule

// File: tb/tb_rggen_register_host.sv
// tb/tb_rggen_register_host.sv - directed self-checking bench for rggen_register_host
module tb_rggen_register_host;

    logic         clk;
    logic         rst;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [15:0]  i_cmd_address;
    logic         i_cmd_write;
    logic [31:0]  i_cmd_write_data;
    logic         o_rsp_valid;
    logic         i_rsp_ready;
    logic [31:0]  o_rsp_read_data;
    logic [1:0]   o_rsp_status;
    logic         o_register_request;
    logic [15:0]  o_register_address;
    logic         o_register_write;
    logic [31:0]  o_register_write_data;
    logic [3:0]   i_register_select;
    logic [3:0]   i_register_ready;
    logic [127:0] i_register_read_data;
    logic [7:0]   i_register_status;

    int n_checks;
    int n_fail;

    rggen_register_host #(
        .ADDRESS_WIDTH  (16),
        .DATA_WIDTH     (32),
        .REGISTERS      (4),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_cmd_valid           (i_cmd_valid),
        .o_cmd_ready           (o_cmd_ready),
        .i_cmd_address         (i_cmd_address),
        .i_cmd_write           (i_cmd_write),
        .i_cmd_write_data      (i_cmd_write_data),
        .o_rsp_valid           (o_rsp_valid),
        .i_rsp_ready           (i_rsp_ready),
        .o_rsp_read_data       (o_rsp_read_data),
        .o_rsp_status          (o_rsp_status),
        .o_register_request    (o_register_request),
        .o_register_address    (o_register_address),
        .o_register_write      (o_register_write),
        .o_register_write_data (o_register_write_data),
        .i_register_select     (i_register_select),
        .i_register_ready      (i_register_ready),
        .i_register_read_data  (i_register_read_data),
        .i_register_status     (i_register_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; afterwards the DUT is in its first ACCESS cycle.
    task automatic issue(input logic [15:0] addr, input logic wr, input logic [31:0] wdata);
        i_cmd_valid      = 1'b1;
        i_cmd_address    = addr;
        i_cmd_write      = wr;
        i_cmd_write_data = wdata;
        check("cmd_ready_idle", o_cmd_ready, 1);
        step();
        i_cmd_valid = 1'b0;
        check("request_T1", o_register_request, 1);
        check("cmd_ready_access", o_cmd_ready, 0);
    endtask

    // Consume a pending response with no backpressure.
    task automatic accept();
        i_rsp_ready = 1'b1;
        step();
        i_rsp_ready       = 1'b0;
        i_register_select = 4'b0;
        i_register_ready  = 4'b0;
        check("rsp_valid_cleared", o_rsp_valid, 0);
        check("cmd_ready_after_rsp", o_cmd_ready, 1);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        i_cmd_valid = 1'b0; i_cmd_address = '0; i_cmd_write = 1'b0; i_cmd_write_data = '0;
        i_rsp_ready = 1'b0;
        i_register_select = '0; i_register_ready = '0;
        i_register_read_data = '0; i_register_status = '0;

        // Reset state
        step(); step();
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_data", o_rsp_read_data, 0);
        check("rst_rsp_status", o_rsp_status, 0);
        check("rst_request", o_register_request, 0);
        check("rst_address", o_register_address, 0);
        check("rst_write", o_register_write, 0);
        check("rst_wdata", o_register_write_data, 0);
        rst = 1'b0;
        #1;

        // Read hit: slot 2 ready immediately
        i_register_read_data[64 +: 32] = 32'hDEADBEEF;
        i_register_status[4 +: 2]      = 2'b00;
        issue(16'h0008, 1'b0, 32'h0);
        check("rd_address", o_register_address, 16'h0008);
        check("rd_write_flag", o_register_write, 0);
        i_register_select = 4'b0100;
        i_register_ready  = 4'b0100;
        step();
        check("rd_rsp_valid_T2", o_rsp_valid, 1);
        check("rd_request_low", o_register_request, 0);
        check("rd_data", o_rsp_read_data, 32'hDEADBEEF);
        check("rd_status", o_rsp_status, 2'b00);
        accept();

        // Write with wait states on slot 0; slot returns EXOKAY and junk read data
        i_register_read_data[0 +: 32] = 32'hAAAA5555;
        i_register_status[0 +: 2]     = 2'b01;
        issue(16'h0010, 1'b1, 32'h12345678);
        i_register_select = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            check("wr_request", o_register_request, 1);
            check("wr_address", o_register_address, 16'h0010);
            check("wr_wdata", o_register_write_data, 32'h12345678);
            check("wr_rsp_valid_low", o_rsp_valid, 0);
            if (i == 2) i_register_ready = 4'b0001;
            step();
        end
        check("wr_rsp_valid", o_rsp_valid, 1);
        check("wr_request_low", o_register_request, 0);
        check("wr_data_zero", o_rsp_read_data, 0);
        check("wr_exokay_to_okay", o_rsp_status, 2'b00);
        check("wr_addr_held", o_register_address, 16'h0010);
        accept();

        // Slave error status returned by the selected register
        i_register_read_data[96 +: 32] = 32'h0BADF00D;
        i_register_status[6 +: 2]      = 2'b10;
        issue(16'h000C, 1'b0, 32'h0);
        i_register_select = 4'b1000;
        i_register_ready  = 4'b1000;
        step();
        check("slverr_status", o_rsp_status, 2'b10);
        check("slverr_data", o_rsp_read_data, 32'h0BADF00D);
        accept();

        // Decode error: no select
        issue(16'h0100, 1'b0, 32'h0);
        step();
        check("dec_none_valid_T2", o_rsp_valid, 1);
        check("dec_none_status", o_rsp_status, 2'b11);
        check("dec_none_data", o_rsp_read_data, 0);
        accept();

        // Decode error: two selects, both ready
        issue(16'h0004, 1'b0, 32'h0);
        i_register_select = 4'b0110;
        i_register_ready  = 4'b0110;
        step();
        check("dec_multi_valid_T2", o_rsp_valid, 1);
        check("dec_multi_status", o_rsp_status, 2'b11);
        check("dec_multi_data", o_rsp_read_data, 0);
        accept();

        // Timeout: slot 1 selected, never ready
        i_register_read_data[32 +: 32] = 32'h5A5A5A5A;
        issue(16'h0004, 1'b0, 32'h0);
        i_register_select = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            check("to_request", o_register_request, 1);
            check("to_rsp_valid_low", o_rsp_valid, 0);
            step();
        end
        check("to_request_low", o_register_request, 0);
        check("to_rsp_valid", o_rsp_valid, 1);
        check("to_status", o_rsp_status, 2'b10);
        check("to_data", o_rsp_read_data, 0);

        // Backpressure on the timeout response
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rsp_valid", o_rsp_valid, 1);
            check("bp_status", o_rsp_status, 2'b10);
            check("bp_data", o_rsp_read_data, 0);
            check("bp_cmd_ready", o_cmd_ready, 0);
        end
        i_cmd_valid = 1'b1;
        check("bp_cmd_ready_hs_cycle", o_cmd_ready, 0);
        i_cmd_valid = 1'b0;
        accept();

        // Counter restarts: ready on the 4th ACCESS cycle still completes OKAY
        issue(16'h0004, 1'b0, 32'h0);
        i_register_select = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            check("restart_request", o_register_request, 1);
            if (i == 3) i_register_ready = 4'b0010;
            step();
        end
        check("restart_rsp_valid", o_rsp_valid, 1);
        check("restart_status", o_rsp_status, 2'b00);
        check("restart_data", o_rsp_read_data, 32'h5A5A5A5A);
        accept();

        // Reset on the second ACCESS cycle drops the access
        issue(16'h0020, 1'b1, 32'hCAFEF00D);
        i_register_select = 4'b0001;
        step();
        check("mid_request_2nd", o_register_request, 1);
        rst = 1'b1;
        step();
        check("mid_rst_request", o_register_request, 0);
        check("mid_rst_rsp_valid", o_rsp_valid, 0);
        check("mid_rst_cmd_ready", o_cmd_ready, 0);
        rst = 1'b0;
        i_register_select = 4'b0;
        #1;
        check("mid_cmd_ready_back", o_cmd_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_rsp", o_rsp_valid, 0);
        end

        // Normal access after reset
        i_register_read_data[96 +: 32] = 32'h13579BDF;
        i_register_status[6 +: 2]      = 2'b00;
        issue(16'h000C, 1'b0, 32'h0);
        i_register_select = 4'b1000;
        i_register_ready  = 4'b1000;
        step();
        check("post_rst_rsp_valid", o_rsp_valid, 1);
        check("post_rst_data", o_rsp_read_data, 32'h13579BDF);
        check("post_rst_status", o_rsp_status, 2'b00);
        accept();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rggen_register_host.md
# rggen_register_host

Initiator-side controller for the register access bus. It accepts one host command at a time on a valid/ready channel and broadcasts it to all register blocks as request/address/write/write_data. It then collects the per-register select/ready/read_data/status replies and returns one response on a valid/ready channel. It sits between the protocol bridge (APB/AXI4-Lite/Wishbone front end) and the register array, and drives the bus that each register's decoder answers.

## Interface
Parameters:
- ADDRESS_WIDTH, 16, byte address width.
- DATA_WIDTH, 32, data width; a multiple of 8.
- REGISTERS, 1, number of register reply slots (≥1).
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed without ready before abort (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  host command valid.
- o_cmd_ready  out  1  command accepted when valid & ready.
- i_cmd_address  in  ADDRESS_WIDTH  byte address.
- i_cmd_write  in  1  1 = write, 0 = read.
- i_cmd_write_data  in  DATA_WIDTH  write data.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response consumed when valid & ready.
- o_rsp_read_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- o_rsp_status  out  2  00 OKAY, 10 SLAVE_ERROR, 11 DECODE_ERROR.
- o_register_request  out  1  access in progress.
- o_register_address  out  ADDRESS_WIDTH  latched address.
- o_register_write  out  1  latched write flag.
- o_register_write_data  out  DATA_WIDTH  latched write data.
- i_register_select  in  REGISTERS  per-register address hit.
- i_register_ready  in  REGISTERS  per-register completion; may equal request & select in the same cycle.
- i_register_read_data  in  REGISTERS*DATA_WIDTH  slot k at [k*DATA_WIDTH +: DATA_WIDTH].
- i_register_status  in  REGISTERS*2  slot k at [2k +: 2].

## Operation
- FSM states: IDLE, ACCESS, RESPONSE. Reset → IDLE.
- IDLE: o_cmd_ready = 1, gated low while rst = 1. On handshake, latch address/write/write_data into the o_register_* registers and go to ACCESS. Clear the timeout counter.
- ACCESS: o_register_request = 1. Per cycle, evaluate in priority order:
  1. If no select bit is set or more than one is set: DECODE_ERROR, read data 0, go to RESPONSE.
  2. Else if selected slot k has ready = 1: capture read data of slot k (forced 0 if write) and status of slot k; go to RESPONSE.
  3. Else if counter == TIMEOUT_CYCLES-1: SLAVE_ERROR, read data 0, go to RESPONSE.
  4. Else increment the counter. Counter width is $clog2(TIMEOUT_CYCLES+1) and it never wraps.
- A captured slave status of 01 (EXOKAY) is returned as 00.
- RESPONSE: o_rsp_valid = 1. Read data and status are held stable until i_rsp_ready, then go to IDLE.
- The o_register_* address/write/data outputs hold their last value outside ACCESS; only request qualifies them.
- Reset mid-operation (any state): next edge state = IDLE, request = 0, rsp_valid = 0; the pending access is dropped with no response.

## Timing
- Reset values: o_cmd_ready 0 during rst; o_rsp_valid 0; o_rsp_read_data 0; o_rsp_status 00; o_register_request 0; address/write/data 0.
- Command handshake at cycle T → request high at T+1.
- Ready seen at T+n (n ≥ 1) → o_rsp_valid at T+n+1; request low from T+n+1.
- Timeout → request high for exactly TIMEOUT_CYCLES cycles; response on the following cycle.
- Decode error → response at T+2.
- Response handshake at R → o_cmd_ready = 1 at R+1. Minimum 3 cycles per access.
- o_cmd_ready is 0 throughout ACCESS and RESPONSE. No command is accepted during the response handshake cycle.

## Test plan
- Read hit: REGISTERS=4, slot 2 selects and is ready immediately with data 0xDEADBEEF, status 00 → request high 1 cycle; response at T+2 with 0xDEADBEEF/00.
- Write with wait states: slot 0 ready 3 cycles after request, write_data 0x12345678 → request high 3 cycles, address/data stable; response has read data 0, status 00.
- Decode error: address with no select, and separately two selects → status 11, data 0, response at T+2.
- Timeout: TIMEOUT_CYCLES=4, select without ready → request high 4 cycles; status 10; counter restarts at 0 on the next command.
- Backpressure: hold i_rsp_ready low 5 cycles → data/status stable, o_cmd_ready 0; ready at R gives o_cmd_ready 1 at R+1.
- Reset mid-ACCESS: assert rst for 1 cycle on the 2nd request cycle → request 0, no o_rsp_valid; next command completes normally.
